// File: rtl/daq_controller.sv
// daq_controller: acquisition sequencer for the muon DAQ event path.
// It turns raw trigger edges into qualified capture pulses, waits for each
// event to be stored, applies a programmable holdoff, and keeps accepted-event
// and lost-trigger counters plus a sticky timeout flag.
module daq_controller #(
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [7:0]           cmd,
  input  logic                 cmd_valid,
  input  logic                 trig_i,
  input  logic                 event_saved_i,
  input  logic                 full_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic                 trig_o,
  output logic                 armed_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic [31:0]          evt_count_o,
  output logic [15:0]          lost_count_o
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLDOFF = 2'd3
  } state_e;

  typedef enum logic [7:0] {
    CMD_ARM    = 8'h01,
    CMD_DISARM = 8'h02,
    CMD_SINGLE = 8'h03,
    CMD_CLEAR  = 8'h04
  } cmd_e;

  state_e                 state_q, state_d;
  logic                   trig_q;
  logic                   single_q, single_d;
  logic                   disarm_pend_q, disarm_pend_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic [HOLDOFF_W-1:0]   hold_q, hold_d;
  logic [31:0]            evt_q, evt_d;
  logic [15:0]            lost_q, lost_d;
  logic                   timeout_q, timeout_d;
  logic                   trig_out_q, trig_out_d;
  logic                   armed_q, busy_q;

  logic trig_edge;
  logic is_arm, is_disarm, is_single, is_clear;
  logic evt_inc, lost_inc;

  assign trig_edge = trig_i & ~trig_q;
  assign is_arm    = cmd_valid && (cmd == CMD_ARM);
  assign is_disarm = cmd_valid && (cmd == CMD_DISARM);
  assign is_single = cmd_valid && (cmd == CMD_SINGLE);
  assign is_clear  = cmd_valid && (cmd == CMD_CLEAR);

  // Next-state, counter and pulse computation for one clock cycle.
  always_comb begin
    state_d       = state_q;
    single_d      = single_q;
    disarm_pend_d = disarm_pend_q;
    tmo_d         = tmo_q;
    hold_d        = hold_q;
    timeout_d     = timeout_q;
    trig_out_d    = 1'b0;
    evt_inc       = 1'b0;
    lost_inc      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (is_arm) begin
          state_d  = S_ARMED;
          single_d = 1'b0;
        end else if (is_single) begin
          state_d  = S_ARMED;
          single_d = 1'b1;
        end
      end
      S_ARMED: begin
        // DISARM suppresses any edge seen in the same cycle.
        if (is_disarm) begin
          state_d = S_IDLE;
        end else begin
          if (is_arm)         single_d = 1'b0;
          else if (is_single) single_d = 1'b1;
          if (trig_edge) begin
            if (full_i) begin
              lost_inc = 1'b1;
            end else begin
              trig_out_d = 1'b1;
              state_d    = S_CAPTURE;
              tmo_d      = '0;
            end
          end
        end
      end
      S_CAPTURE: begin
        lost_inc = trig_edge;
        if (is_disarm) disarm_pend_d = 1'b1;
        if (event_saved_i) begin
          evt_inc = 1'b1;
          if (single_q || disarm_pend_q || is_disarm) begin
            state_d = S_IDLE;
          end else if (holdoff_i == '0) begin
            state_d = S_ARMED;
          end else begin
            state_d = S_HOLDOFF;
            hold_d  = holdoff_i;
          end
        end else if (tmo_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_HOLDOFF: begin
        lost_inc = trig_edge;
        if (is_disarm) begin
          state_d = S_IDLE;
        end else if (hold_q <= HOLDOFF_W'(1)) begin
          state_d = S_ARMED;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) disarm_pend_d = 1'b0;

    evt_d  = evt_inc ? (evt_q + 32'd1) : evt_q;
    lost_d = (lost_inc && (lost_q != '1)) ? (lost_q + 16'd1) : lost_q;

    // CLEAR overrides any increment or timeout raised in the same cycle.
    if (is_clear) begin
      evt_d     = '0;
      lost_d    = '0;
      timeout_d = 1'b0;
    end
  end

  // State, counters and registered output decodes.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      trig_q        <= 1'b0;
      single_q      <= 1'b0;
      disarm_pend_q <= 1'b0;
      tmo_q         <= '0;
      hold_q        <= '0;
      evt_q         <= '0;
      lost_q        <= '0;
      timeout_q     <= 1'b0;
      trig_out_q    <= 1'b0;
      armed_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trig_i;
      single_q      <= single_d;
      disarm_pend_q <= disarm_pend_d;
      tmo_q         <= tmo_d;
      hold_q        <= hold_d;
      evt_q         <= evt_d;
      lost_q        <= lost_d;
      timeout_q     <= timeout_d;
      trig_out_q    <= trig_out_d;
      armed_q       <= (state_d == S_ARMED);
      busy_q        <= (state_d == S_CAPTURE) || (state_d == S_HOLDOFF);
    end
  end

  assign trig_o       = trig_out_q;
  assign armed_o      = armed_q;
  assign busy_o       = busy_q;
  assign timeout_o    = timeout_q;
  assign evt_count_o  = evt_q;
  assign lost_count_o = lost_q;

endmodule

// File: tb/tb_daq_controller.sv
// Testbench for daq_controller: vector table, directed corner sequences and
// a randomized run compared against a cycle-count based reference model.
module tb_daq_controller;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [7:0]  cmd;
  logic        cmd_valid, trig_i, event_saved_i, full_i;
  logic [15:0] holdoff_i;
  logic        trig_o, armed_o, busy_o, timeout_o;
  logic [31:0] evt_count_o;
  logic [15:0] lost_count_o;

  int n_err = 0;
  int n_checks = 0;

  daq_controller #(.TIMEOUT(TMO), .HOLDOFF_W(16)) dut (
    .clk(clk), .aresetn(aresetn), .cmd(cmd), .cmd_valid(cmd_valid),
    .trig_i(trig_i), .event_saved_i(event_saved_i), .full_i(full_i),
    .holdoff_i(holdoff_i), .trig_o(trig_o), .armed_o(armed_o),
    .busy_o(busy_o), .timeout_o(timeout_o), .evt_count_o(evt_count_o),
    .lost_count_o(lost_count_o)
  );

  always #5 clk = ~clk;

  // Reference model: phases plus absolute cycle stamps for deadlines.
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_HOLD = 3;
  int          m_mode, p, m_cap_start, m_rearm_at;
  bit          m_single, m_dpend, m_trig_prev, m_tmo, m_trigo;
  logic [31:0] m_evt;
  logic [15:0] m_lost;

  task automatic model_reset();
    m_mode = M_IDLE; p = 0; m_cap_start = 0; m_rearm_at = 0;
    m_single = 0; m_dpend = 0; m_trig_prev = 0; m_tmo = 0; m_trigo = 0;
    m_evt = '0; m_lost = '0;
  endtask

  task automatic model_update(input logic [7:0] c, input logic cv, input logic t,
                              input logic s, input logic f, input logic [15:0] h);
    bit edge_s, arm, dis, sgl, clr, nt, inc_e, inc_l;
    int nm;
    p++;
    edge_s = t && !m_trig_prev;
    m_trig_prev = t;
    arm = cv && (c == 8'h01);
    dis = cv && (c == 8'h02);
    sgl = cv && (c == 8'h03);
    clr = cv && (c == 8'h04);
    nm = m_mode; nt = 0; inc_e = 0; inc_l = 0;
    if (m_mode == M_IDLE) begin
      if (arm) begin nm = M_ARMED; m_single = 0; end
      else if (sgl) begin nm = M_ARMED; m_single = 1; end
    end else if (m_mode == M_ARMED) begin
      if (dis) nm = M_IDLE;
      else begin
        if (arm) m_single = 0;
        else if (sgl) m_single = 1;
        if (edge_s) begin
          if (f) inc_l = 1;
          else begin nt = 1; nm = M_CAP; m_cap_start = p; end
        end
      end
    end else if (m_mode == M_CAP) begin
      inc_l = edge_s;
      if (s) begin
        inc_e = 1;
        if (m_single || m_dpend || dis) nm = M_IDLE;
        else if (h == 0) nm = M_ARMED;
        else begin nm = M_HOLD; m_rearm_at = p + int'(h); end
      end else if (p - m_cap_start >= int'(TMO)) begin
        m_tmo = 1; nm = M_IDLE;
      end
      if (dis) m_dpend = 1;
    end else begin
      inc_l = edge_s;
      if (dis) nm = M_IDLE;
      else if (p >= m_rearm_at) nm = M_ARMED;
    end
    if (nm == M_IDLE) m_dpend = 0;
    if (clr) begin
      m_evt = '0; m_lost = '0; m_tmo = 0;
    end else begin
      if (inc_e) m_evt = m_evt + 32'd1;
      if (inc_l && m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
    end
    m_mode = nm;
    m_trigo = nt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("trig_o", trig_o, m_trigo);
    chk("armed_o", armed_o, m_mode == M_ARMED);
    chk("busy_o", busy_o, (m_mode == M_CAP) || (m_mode == M_HOLD));
    chk("timeout_o", timeout_o, m_tmo);
    chk("evt_count_o", evt_count_o, m_evt);
    chk("lost_count_o", lost_count_o, m_lost);
  endtask

  // Drive one cycle of inputs, advance one clock, update the model.
  task automatic step(input logic [7:0] c, input logic cv, input logic t,
                      input logic s, input logic f, input logic [15:0] h);
    cmd = c; cmd_valid = cv; trig_i = t; event_saved_i = s; full_i = f; holdoff_i = h;
    @(posedge clk);
    model_update(c, cv, t, s, f, h);
    #1;
  endtask

  task automatic run(input logic [7:0] c, input logic cv, input logic t,
                     input logic s, input logic f, input logic [15:0] h);
    step(c, cv, t, s, f, h);
    check_model();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cmd = '0; cmd_valid = 0; trig_i = 0; event_saved_i = 0; full_i = 0; holdoff_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic        cv, t, s, f;
    logic [15:0] h;
    logic        e_trig, e_armed, e_busy;
    logic [31:0] e_evt;
    logic [15:0] e_lost;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] c, input logic cv, input logic t,
                              input logic s, input logic f, input logic [15:0] h,
                              input logic et, input logic ea, input logic eb,
                              input logic [31:0] ee, input logic [15:0] el);
    vec_t v;
    v.cmd = c; v.cv = cv; v.t = t; v.s = s; v.f = f; v.h = h;
    v.e_trig = et; v.e_armed = ea; v.e_busy = eb; v.e_evt = ee; v.e_lost = el;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    int pulses, n;
    logic [7:0] rc;

    //            cmd   cv t  s  f  h     trig armed busy evt lost
    vecs[0]  = mk(8'h01, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0);  // ARM
    vecs[1]  = mk(8'h00, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0);  // edge -> capture
    vecs[2]  = mk(8'h00, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0);  // held high
    vecs[3]  = mk(8'h00, 0, 0, 1, 0, 2,   0, 0, 1, 1, 0);  // saved -> holdoff 2
    vecs[4]  = mk(8'h00, 0, 1, 0, 0, 0,   0, 0, 1, 1, 1);  // edge in holdoff
    vecs[5]  = mk(8'h00, 0, 0, 0, 0, 0,   0, 1, 0, 1, 1);  // rearm after 2
    vecs[6]  = mk(8'h00, 0, 1, 0, 1, 0,   0, 1, 0, 1, 2);  // edge while full
    vecs[7]  = mk(8'h00, 0, 0, 0, 1, 0,   0, 1, 0, 1, 2);
    vecs[8]  = mk(8'h02, 1, 1, 0, 0, 0,   0, 0, 0, 1, 2);  // DISARM beats edge
    vecs[9]  = mk(8'h00, 0, 0, 0, 0, 0,   0, 0, 0, 1, 2);
    vecs[10] = mk(8'h00, 0, 1, 0, 0, 0,   0, 0, 0, 1, 2);  // edge in idle
    vecs[11] = mk(8'h04, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // CLEAR
    vecs[12] = mk(8'h03, 1, 0, 0, 0, 0,   0, 1, 0, 0, 0);  // SINGLE
    vecs[13] = mk(8'h00, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0);
    vecs[14] = mk(8'h00, 0, 0, 1, 0, 3,   0, 0, 0, 1, 0);  // single -> idle
    vecs[15] = mk(8'h00, 0, 0, 1, 0, 0,   0, 0, 0, 1, 0);  // saved outside capture

    do_reset();
    #1;
    chk("rst_trig", trig_o, 0);
    chk("rst_armed", armed_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_evt", evt_count_o, 0);
    chk("rst_lost", lost_count_o, 0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].cmd, vecs[i].cv, vecs[i].t, vecs[i].s, vecs[i].f, vecs[i].h);
      chk($sformatf("v%0d_trig", i), trig_o, vecs[i].e_trig);
      chk($sformatf("v%0d_armed", i), armed_o, vecs[i].e_armed);
      chk($sformatf("v%0d_busy", i), busy_o, vecs[i].e_busy);
      chk($sformatf("v%0d_timeout", i), timeout_o, 0);
      chk($sformatf("v%0d_evt", i), evt_count_o, vecs[i].e_evt);
      chk($sformatf("v%0d_lost", i), lost_count_o, vecs[i].e_lost);
    end

    // Timeout: no event_saved after the capture trigger.
    do_reset();
    run(8'h01, 1, 0, 0, 0, 0);
    run(8'h00, 0, 1, 0, 0, 0);
    chk("tmo_trig", trig_o, 1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      run(8'h00, 0, 0, 0, 0, 0);
      if (timeout_o) begin n = k; break; end
    end
    chk("tmo_latency", n, TMO);
    chk("tmo_idle", armed_o | busy_o, 0);
    run(8'h04, 1, 0, 0, 0, 0);
    chk("tmo_clear", timeout_o, 0);

    // Full FIFO: edges are lost, then accepted once full drops.
    pulses = 0;
    run(8'h01, 1, 0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      run(8'h00, 0, 1, 0, 1, 0); pulses += int'(trig_o);
      run(8'h00, 0, 0, 0, 1, 0); pulses += int'(trig_o);
    end
    chk("full_pulses", pulses, 0);
    chk("full_lost", lost_count_o, 4);
    run(8'h00, 0, 1, 0, 0, 0);
    chk("full_drop_trig", trig_o, 1);

    // DISARM during capture lets the capture finish, then goes idle.
    run(8'h02, 1, 0, 0, 0, 0);
    chk("dis_busy", busy_o, 1);
    run(8'h00, 0, 0, 1, 0, 3);
    chk("dis_evt", evt_count_o, 1);
    chk("dis_idle", armed_o | busy_o, 0);
    run(8'h01, 1, 0, 0, 0, 0);
    run(8'h00, 0, 1, 0, 0, 0);
    run(8'h02, 1, 0, 0, 0, 0);
    run(8'h04, 1, 0, 1, 0, 3);  // CLEAR together with event_saved
    chk("clr_evt", evt_count_o, 0);
    chk("clr_idle", armed_o | busy_o, 0);

    // Lost counter saturation in holdoff, then async reset mid-holdoff.
    do_reset();
    run(8'h01, 1, 0, 0, 0, 0);
    run(8'h00, 0, 1, 0, 0, 0);
    run(8'h00, 0, 0, 1, 0, 20);
    force dut.lost_d = 16'hFFFD;
    step(8'h00, 0, 0, 0, 0, 20);
    release dut.lost_d;
    m_lost = 16'hFFFD;
    check_model();
    for (int k = 0; k < 3; k++) begin
      run(8'h00, 0, 1, 0, 0, 20);
      run(8'h00, 0, 0, 0, 0, 20);
    end
    chk("sat_lost", lost_count_o, 16'hFFFF);
    chk("sat_busy", busy_o, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_trig", trig_o, 0);
    chk("arst_armed", armed_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_timeout", timeout_o, 0);
    chk("arst_evt", evt_count_o, 0);
    chk("arst_lost", lost_count_o, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rc = 8'($urandom_range(0, 5));
      run(rc, ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
          16'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/daq_controller.md
# daq_controller

Acquisition sequencer for the muon DAQ, clocked in the 125 MHz event-path domain. It accepts host commands, converts the raw threshold trigger into qualified single-cycle capture triggers for the sampler and event saver, and waits for each event to be stored. It enforces a programmable holdoff, refuses triggers while the event FIFO is full, and keeps accepted-event and lost-trigger counters plus a timeout flag for the readout path.

## Interface
Parameters:
- TIMEOUT, 4096, max cycles to wait for event_saved_i after a trigger
- HOLDOFF_W, 16, width of holdoff_i and the holdoff counter

Ports:
- clk  in  1  125 MHz event clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- cmd  in  8  command byte, sampled when cmd_valid=1
- cmd_valid  in  1  one-cycle command strobe
- trig_i  in  1  raw threshold trigger, synchronous to clk, level
- event_saved_i  in  1  one-cycle pulse: event fully written to FIFO
- full_i  in  1  event FIFO full
- holdoff_i  in  HOLDOFF_W  dead time after each event, in cycles
- trig_o  out  1  qualified capture trigger, one-cycle pulse
- armed_o  out  1  high in ARMED
- busy_o  out  1  high in CAPTURE or HOLDOFF
- timeout_o  out  1  sticky: event_saved_i not seen within TIMEOUT
- evt_count_o  out  32  accepted events, wraps modulo 2^32
- lost_count_o  out  16  rejected trigger edges, saturates at 0xFFFF

## Operation
- Commands: 0x01 ARM (continuous), 0x02 DISARM, 0x03 SINGLE (one event, then IDLE), 0x04 CLEAR. All other codes are ignored.
- CLEAR zeroes evt_count_o, lost_count_o and timeout_o in any state. It does not change state.
- Edge detect: trig_q <= trig_i. edge = trig_i & ~trig_q. Only edges count. A held-high trigger gives exactly one edge.
- State IDLE: edges are ignored and not counted. ARM → ARMED with single=0. SINGLE → ARMED with single=1.
- State ARMED:
  - edge & !full_i → trig_o pulse, go to CAPTURE, clear timeout counter.
  - edge & full_i → lost++, stay in ARMED.
  - DISARM → IDLE. A repeated ARM or SINGLE only updates the single flag.
- State CAPTURE:
  - event_saved_i → evt_count++.
  - Next state after event_saved_i: IDLE if single or disarm_pend. Otherwise ARMED if holdoff_i==0. Otherwise HOLDOFF, with the counter loaded from holdoff_i.
  - Timeout counter reaching TIMEOUT-1 without event_saved_i → timeout_o=1, go to IDLE, no count.
  - DISARM sets disarm_pend, and the capture completes normally. disarm_pend clears on entry to IDLE.
- State HOLDOFF: counter decrements each cycle. Return to ARMED when it reaches 1, so ARMED is re-entered exactly holdoff_i cycles after leaving CAPTURE. DISARM → IDLE immediately.
- Edges seen in CAPTURE or HOLDOFF → lost++.
- Simultaneous events:
  - CLEAR with a count increment in the same cycle: CLEAR wins, the counter ends at 0.
  - DISARM with an edge in ARMED in the same cycle: DISARM wins, no trig_o, no lost++.
  - event_saved_i outside CAPTURE is ignored.
- lost_count_o holds at 0xFFFF once saturated. evt_count_o rolls from 0xFFFFFFFF to 0.

## Timing
- Reset (aresetn=0, asynchronous): state IDLE. All outputs 0. trig_q, single, disarm_pend and all internal counters are 0.
- trig_o is registered. An edge in cycle k (trig_i=1, trig_q=0) gives trig_o=1 in cycle k+1 only. busy_o=1 from k+1.
- armed_o and busy_o are registered decodes of the state, valid in the cycle the state is entered.
- Command effect is visible in the cycle after the cmd_valid cycle.
- Counter update is visible in the cycle after the qualifying edge or pulse.
- Trigger-to-rearm minimum: 1 (trig_o) + capture wait + holdoff_i cycles.
- Reset asserted mid-CAPTURE aborts the capture. No count is kept, and nothing is retained.

## Test plan
- Reset, ARM, trig_i edge at cycle 10, event_saved_i at 20, holdoff_i=5 → trig_o only at 11. evt_count_o=1 at 21. armed_o=1 again 5 cycles after leaving CAPTURE.
- SINGLE, then 3 trigger edges spaced 50 cycles apart, each answered by event_saved_i → one trig_o, evt_count_o=1, lost_count_o=0, state IDLE after the first.
- ARM with full_i=1, 4 edges → no trig_o, lost_count_o=4. Drop full_i, next edge → trig_o.
- ARM, edge, never send event_saved_i, TIMEOUT=16 → timeout_o=1 and IDLE 16 cycles after trig_o. CLEAR → timeout_o=0.
- DISARM during CAPTURE, then event_saved_i → evt_count_o increments and state goes to IDLE, not HOLDOFF. CLEAR in the same cycle as event_saved_i → evt_count_o=0.
- Preload 65535 lost edges (force), then 2 more edges in HOLDOFF → lost_count_o stays 0xFFFF. Assert aresetn=0 mid-HOLDOFF → all outputs 0 immediately.
